// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared defaults and types for the UART receive buffer.
// Revision: 1.0
`default_nettype none

package uart_rx_fifo_pkg;

  localparam int UART_RXF_DEPTH   = 16;
  localparam int UART_RXF_THRESH  = 8;
  localparam int UART_RXF_TIMEOUT = 4096;

  typedef logic [7:0] rx_byte_t;

  localparam rx_byte_t DATA_REG_DFT = 8'hff;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 8 storage, one write port, one registered read port.
// Revision: 1.0
`default_nettype none

module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RXF_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_byte_t      wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output rx_byte_t      rdata
);

  // Storage carries no reset; only the read register returns to a known value.
  rx_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= DATA_REG_DFT;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-captured UART receive FIFO with level flags, sticky errors,
// character timeout and threshold interrupt.  Revision: 1.0
`default_nettype none

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH       = UART_RXF_DEPTH,
  parameter int AW          = 4,
  parameter int RX_THRESH   = UART_RXF_THRESH,
  parameter int TIMEOUT_CYC = UART_RXF_TIMEOUT,
  parameter int TW          = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rx_ok,
  input  logic [7:0]  rx_data,
  input  logic        parity_error,
  output logic        rx_rd_flag,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level,
  output logic        overrun,
  output logic        par_err,
  input  logic        err_clr,
  output logic        timeout,
  output logic        irq
);

  localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_THRESH = (AW+1)'(RX_THRESH);
  localparam logic [TW-1:0] CNT_MAX    = TW'(TIMEOUT_CYC);

  logic          rx_ok_d;
  logic          par_d;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [TW-1:0] cnt;

  logic          push_edge;
  logic          par_rise;
  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic [AW:0]   level_nxt;
  logic [TW-1:0] cnt_nxt;

  assign push_edge = rx_ok & ~rx_ok_d;
  assign par_rise  = parity_error & ~par_d;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign timeout = (cnt == CNT_MAX);

  // A pop on a full FIFO frees the slot the coincident push lands in.
  assign do_pop  = rd_en & ~empty & ~flush;
  assign do_push = push_edge & ~flush & (~full | do_pop);
  assign drop    = push_edge & ~flush & full & ~do_pop;

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (do_push && !do_pop) begin
      level_nxt = level + 1'b1;
    end else if (do_pop && !do_push) begin
      level_nxt = level - 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (flush || push_edge || do_pop || empty) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (do_push),
    .waddr (wp),
    .wdata (rx_data),
    .re    (do_pop),
    .raddr (rp),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ok_d    <= 1'b0;
      par_d      <= 1'b0;
      rx_rd_flag <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      cnt        <= '0;
      rd_valid   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rx_ok_d    <= rx_ok;
      par_d      <= parity_error;
      rx_rd_flag <= 1'b1;
      level      <= level_nxt;
      cnt        <= cnt_nxt;
      rd_valid   <= do_pop;
      irq        <= (level_nxt >= LVL_THRESH) | (cnt_nxt == CNT_MAX);
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (do_push) wp <= wp + 1'b1;
        if (do_pop)  rp <= rp + 1'b1;
      end
    end
  end

  // Set events take precedence over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (par_rise) begin
        par_err <= 1'b1;
      end else if (err_clr) begin
        par_err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-driven bench for uart_rx_fifo.
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       rx_ok = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       parity_error = 1'b0;
  logic       rx_rd_flag;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       par_err;
  logic       err_clr = 1'b0;
  logic       timeout;
  logic       irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic [7:0] last_rd = 8'hff;

  localparam logic [20:0] RST_VIEW = {8'hff, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [20:0] view;

  uart_rx_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .rx_ok        (rx_ok),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .rx_rd_flag   (rx_rd_flag),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .overrun      (overrun),
    .par_err      (par_err),
    .err_clr      (err_clr),
    .timeout      (timeout),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ok   = 1'b1;
    @(negedge clk);
    rx_ok   = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got rd_valid=%0b rd_data=%h", name, rd_valid, rd_data);
    end else begin
      e = exp_q.pop_front();
      last_rd = e;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        bad++;
        $display("FAIL %s: got valid=%0b data=%h, want valid=1 data=%h", name, rd_valid, rd_data, e);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    view = {rd_data, rd_valid, empty, full, level, overrun, par_err, timeout, irq, rx_rd_flag};
    total++;
    if (view !== RST_VIEW) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", view, RST_VIEW);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rx_rd_flag !== 1'b1) begin
      bad++;
      $display("FAIL rx_rd_flag: got %0b want 1", rx_rd_flag);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    rx_data = 8'hA5;
    rx_ok   = 1'b1;
    repeat (20) @(negedge clk);
    rx_ok   = 1'b0;
    exp_q.push_back(8'hA5);
    total++;
    if (level !== 5'd1) begin
      bad++;
      $display("FAIL hold_level: got %0d want 1", level);
    end
    pop_check("hold_pop");
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL hold_pulse: got valid=%0b empty=%0b want valid=0 empty=1", rd_valid, empty);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    push_byte(8'hFF);
    total++;
    if (full !== 1'b1 || overrun !== exp_ovr || level !== 5'd16) begin
      bad++;
      $display("FAIL overrun_state: got full=%0b ovr=%0b lvl=%0d want 1 %0b 16", full, overrun, level, exp_ovr);
    end
    for (int i = 0; i < 16; i++) pop_check("overrun_pop");
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    total++;
    if (overrun !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL err_clr: got ovr=%0b empty=%0b want 0 1", overrun, empty);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] e;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    @(negedge clk);
    rx_data = 8'h55;
    rx_ok   = 1'b1;
    rd_en   = 1'b1;
    @(negedge clk);
    rx_ok   = 1'b0;
    rd_en   = 1'b0;
    e = exp_q.pop_front();
    exp_q.push_back(8'h55);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== e || level !== 5'd16 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL full_pushpop: got v=%0b d=%h lvl=%0d ovr=%0b want 1 %h 16 0", rd_valid, rd_data, level, overrun, e);
    end
    while (exp_q.size() > 0) pop_check("full_drain");
    total++;
    if (last_rd !== 8'h55 || empty !== 1'b1) begin
      bad++;
      $display("FAIL full_last: got last=%h empty=%0b want 55 1", rd_data, empty);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
    repeat (4095) @(negedge clk);
    total++;
    if (timeout !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got to=%0b irq=%0b want 0 0", timeout, irq);
    end
    @(negedge clk);
    total++;
    if (timeout !== 1'b1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL timeout_set: got to=%0b irq=%0b want 1 1", timeout, irq);
    end
    pop_check("timeout_pop");
    total++;
    if (timeout !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL timeout_drop: got to=%0b irq=%0b want 0 0", timeout, irq);
    end
    for (int i = 0; i < 6; i++) push_byte(8'h38 + 8'(i));
    total++;
    if (irq !== 1'b1 || timeout !== 1'b0 || level !== 5'd8) begin
      bad++;
      $display("FAIL thresh_irq: got irq=%0b to=%0b lvl=%0d want 1 0 8", irq, timeout, level);
    end
    while (exp_q.size() > 0) pop_check("thresh_drain");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    @(negedge clk);
    rx_data = 8'h99;
    rx_ok   = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    rx_ok   = 1'b0;
    flush   = 1'b0;
    exp_q.delete();
    total++;
    if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: got lvl=%0d empty=%0b v=%0b want 0 1 0", level, empty, rd_valid);
    end
    push_byte(8'h77);
    pop_check("flush_after");
  endtask

  task automatic test_errs_rst();
    @(negedge clk);
    parity_error = 1'b1;
    @(negedge clk);
    parity_error = 1'b0;
    total++;
    if (par_err !== 1'b1) begin
      bad++;
      $display("FAIL par_err: got %0b want 1", par_err);
    end
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
      bad++;
      $display("FAIL empty_pop: got v=%0b d=%h want 0 %h", rd_valid, rd_data, last_rd);
    end
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
    @(negedge clk);
    rx_data = 8'h63;
    rx_ok   = 1'b1;
    #2 rst = 1'b1;
    #1;
    view = {rd_data, rd_valid, empty, full, level, overrun, par_err, timeout, irq, rx_rd_flag};
    total++;
    if (view !== RST_VIEW) begin
      bad++;
      $display("FAIL async_rst: got %h want %h", view, RST_VIEW);
    end
    rx_ok = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (level !== 5'd0 || empty !== 1'b1 || rx_rd_flag !== 1'b1 || par_err !== 1'b0) begin
      bad++;
      $display("FAIL post_rst: got lvl=%0d empty=%0b flag=%0b perr=%0b want 0 1 1 0", level, empty, rx_rd_flag, par_err);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_overrun();
    test_full_pushpop();
    test_timeout();
    test_flush();
    test_errs_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
